// File: rtl/mem_bus_arbiter.sv
// Arbiter sharing one SRAM-like bus between instruction fetch and data access.
// One transaction outstanding at a time, data has fixed priority, sticky watchdog error.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 255,
  parameter int CW      = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_inst_req,
  input  logic [31:0] i_inst_addr,
  output logic [31:0] o_inst_rdata,
  output logic        o_inst_done,
  output logic        o_inst_stallreq,
  input  logic        i_data_req,
  input  logic        i_data_wr,
  input  logic [3:0]  i_data_wen,
  input  logic [31:0] i_data_addr,
  input  logic [31:0] i_data_wdata,
  output logic [31:0] o_data_rdata,
  output logic        o_data_done,
  output logic        o_data_stallreq,
  output logic        o_bus_req,
  output logic        o_bus_wr,
  output logic [3:0]  o_bus_wen,
  output logic [31:0] o_bus_addr,
  output logic [31:0] o_bus_wdata,
  input  logic        i_bus_addr_ok,
  input  logic        i_bus_data_ok,
  input  logic [31:0] i_bus_rdata,
  output logic        o_bus_err,
  output logic [1:0]  o_dbg_state
);

  // Requester side: req and fields held stable until the one-cycle done pulse.
  // Bus side: o_bus_req stays high with stable fields until i_bus_addr_ok is
  // sampled; i_bus_data_ok is only honoured in a later cycle (WAIT).
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_WAIT = 2'd2,
    S_RESP = 2'd3
  } state_t;

  localparam logic [CW-1:0] TO_VAL  = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam bit            WDOG_EN = (TIMEOUT != 0);

  state_t        r_state, w_state;
  logic          r_owner_data, w_owner_data;
  logic          r_bus_req, w_bus_req;
  logic          r_bus_wr, w_bus_wr;
  logic [3:0]    r_bus_wen, w_bus_wen;
  logic [31:0]   r_bus_addr, w_bus_addr;
  logic [31:0]   r_bus_wdata, w_bus_wdata;
  logic [31:0]   r_inst_rdata, w_inst_rdata;
  logic [31:0]   r_data_rdata, w_data_rdata;
  logic          r_inst_done, w_inst_done;
  logic          r_data_done, w_data_done;
  logic [CW-1:0] r_cnt, w_cnt, w_cnt_inc;
  logic          r_bus_err, w_bus_err;

  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  always_comb begin
    w_state      = r_state;
    w_owner_data = r_owner_data;
    w_bus_req    = r_bus_req;
    w_bus_wr     = r_bus_wr;
    w_bus_wen    = r_bus_wen;
    w_bus_addr   = r_bus_addr;
    w_bus_wdata  = r_bus_wdata;
    w_inst_rdata = r_inst_rdata;
    w_data_rdata = r_data_rdata;
    w_inst_done  = 1'b0;
    w_data_done  = 1'b0;
    w_cnt        = r_cnt;
    w_bus_err    = r_bus_err;
    case (r_state)
      S_IDLE: begin
        if (i_data_req) begin
          w_owner_data = 1'b1;
          w_bus_req    = 1'b1;
          w_bus_wr     = i_data_wr;
          w_bus_wen    = i_data_wr ? i_data_wen : 4'b0000;
          w_bus_addr   = i_data_addr;
          w_bus_wdata  = i_data_wr ? i_data_wdata : 32'h0;
          w_cnt        = '0;
          w_state      = S_ADDR;
        end else if (i_inst_req) begin
          w_owner_data = 1'b0;
          w_bus_req    = 1'b1;
          w_bus_wr     = 1'b0;
          w_bus_wen    = 4'b0000;
          w_bus_addr   = i_inst_addr;
          w_bus_wdata  = 32'h0;
          w_cnt        = '0;
          w_state      = S_ADDR;
        end
      end
      S_ADDR: begin
        w_cnt = w_cnt_inc;
        if (i_bus_addr_ok) begin
          w_bus_req = 1'b0;
          w_state   = S_WAIT;
        end
      end
      S_WAIT: begin
        w_cnt = w_cnt_inc;
        if (i_bus_data_ok) begin
          // Writes leave data_rdata untouched so it keeps the last read value.
          if (r_owner_data) begin
            w_data_done = 1'b1;
            if (!r_bus_wr) w_data_rdata = i_bus_rdata;
          end else begin
            w_inst_done  = 1'b1;
            w_inst_rdata = i_bus_rdata;
          end
          w_state = S_RESP;
        end
      end
      S_RESP: begin
        w_state = S_IDLE;
      end
      default: begin
        w_state = S_IDLE;
      end
    endcase
    // Flag is raised on the edge where the counter reaches the limit.
    if (WDOG_EN && (r_state == S_ADDR || r_state == S_WAIT) && (w_cnt_inc >= TO_VAL))
      w_bus_err = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_owner_data <= 1'b0;
      r_bus_req    <= 1'b0;
      r_bus_wr     <= 1'b0;
      r_bus_wen    <= 4'b0000;
      r_bus_addr   <= 32'h0;
      r_bus_wdata  <= 32'h0;
      r_inst_rdata <= 32'h0;
      r_data_rdata <= 32'h0;
      r_inst_done  <= 1'b0;
      r_data_done  <= 1'b0;
      r_cnt        <= '0;
      r_bus_err    <= 1'b0;
    end else begin
      r_state      <= w_state;
      r_owner_data <= w_owner_data;
      r_bus_req    <= w_bus_req;
      r_bus_wr     <= w_bus_wr;
      r_bus_wen    <= w_bus_wen;
      r_bus_addr   <= w_bus_addr;
      r_bus_wdata  <= w_bus_wdata;
      r_inst_rdata <= w_inst_rdata;
      r_data_rdata <= w_data_rdata;
      r_inst_done  <= w_inst_done;
      r_data_done  <= w_data_done;
      r_cnt        <= w_cnt;
      r_bus_err    <= w_bus_err;
    end
  end

  assign o_inst_rdata    = r_inst_rdata;
  assign o_inst_done     = r_inst_done;
  assign o_inst_stallreq = i_inst_req & ~r_inst_done;
  assign o_data_rdata    = r_data_rdata;
  assign o_data_done     = r_data_done;
  assign o_data_stallreq = i_data_req & ~r_data_done;
  assign o_bus_req       = r_bus_req;
  assign o_bus_wr        = r_bus_wr;
  assign o_bus_wen       = r_bus_wen;
  assign o_bus_addr      = r_bus_addr;
  assign o_bus_wdata     = r_bus_wdata;
  assign o_bus_err       = r_bus_err;
  assign o_dbg_state     = r_state;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed and randomised checks of mem_bus_arbiter; a second instance with
// TIMEOUT=4 exercises the watchdog.
module tb_mem_bus_arbiter;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_ADDR = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_inst_req = 1'b0;
  logic [31:0] i_inst_addr = 32'h0;
  logic        i_data_req = 1'b0;
  logic        i_data_wr = 1'b0;
  logic [3:0]  i_data_wen = 4'h0;
  logic [31:0] i_data_addr = 32'h0;
  logic [31:0] i_data_wdata = 32'h0;
  logic        i_bus_addr_ok = 1'b0;
  logic        i_bus_data_ok = 1'b0;
  logic [31:0] i_bus_rdata = 32'h0;

  logic [31:0] o_inst_rdata, o_data_rdata, o_bus_addr, o_bus_wdata;
  logic        o_inst_done, o_inst_stallreq, o_data_done, o_data_stallreq;
  logic        o_bus_req, o_bus_wr, o_bus_err;
  logic [3:0]  o_bus_wen;
  logic [1:0]  o_dbg_state;

  logic [31:0] t_inst_rdata, t_data_rdata, t_bus_addr, t_bus_wdata;
  logic        t_inst_done, t_inst_stallreq, t_data_done, t_data_stallreq;
  logic        t_bus_req, t_bus_wr, t_bus_err;
  logic [3:0]  t_bus_wen;
  logic [1:0]  t_dbg_state;

  int total = 0;
  int bad = 0;
  int n_txn = 0;
  int req_rises = 0;
  logic prev_req = 1'b0;
  logic [31:0] inst_q[$];
  logic [31:0] data_q[$];
  logic [31:0] last_drd = 32'h0;

  mem_bus_arbiter dut (
    .clk(clk), .rst(rst),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr),
    .o_inst_rdata(o_inst_rdata), .o_inst_done(o_inst_done), .o_inst_stallreq(o_inst_stallreq),
    .i_data_req(i_data_req), .i_data_wr(i_data_wr), .i_data_wen(i_data_wen),
    .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
    .o_data_rdata(o_data_rdata), .o_data_done(o_data_done), .o_data_stallreq(o_data_stallreq),
    .o_bus_req(o_bus_req), .o_bus_wr(o_bus_wr), .o_bus_wen(o_bus_wen),
    .o_bus_addr(o_bus_addr), .o_bus_wdata(o_bus_wdata),
    .i_bus_addr_ok(i_bus_addr_ok), .i_bus_data_ok(i_bus_data_ok), .i_bus_rdata(i_bus_rdata),
    .o_bus_err(o_bus_err), .o_dbg_state(o_dbg_state)
  );

  mem_bus_arbiter #(.TIMEOUT(4), .CW(8)) dut_to (
    .clk(clk), .rst(rst),
    .i_inst_req(i_inst_req), .i_inst_addr(i_inst_addr),
    .o_inst_rdata(t_inst_rdata), .o_inst_done(t_inst_done), .o_inst_stallreq(t_inst_stallreq),
    .i_data_req(i_data_req), .i_data_wr(i_data_wr), .i_data_wen(i_data_wen),
    .i_data_addr(i_data_addr), .i_data_wdata(i_data_wdata),
    .o_data_rdata(t_data_rdata), .o_data_done(t_data_done), .o_data_stallreq(t_data_stallreq),
    .o_bus_req(t_bus_req), .o_bus_wr(t_bus_wr), .o_bus_wen(t_bus_wen),
    .o_bus_addr(t_bus_addr), .o_bus_wdata(t_bus_wdata),
    .i_bus_addr_ok(i_bus_addr_ok), .i_bus_data_ok(i_bus_data_ok), .i_bus_rdata(i_bus_rdata),
    .o_bus_err(t_bus_err), .o_dbg_state(t_dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  // bus_req rising-edge monitor on the main instance
  always @(negedge clk) begin
    if (o_bus_req && !prev_req) req_rises++;
    prev_req = o_bus_req;
  end

  // driver helpers
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    @(negedge clk);
  endtask

  // scoreboard / comparison helpers
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %b want %b", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input bit is_data, input logic [31:0] obs);
    logic [31:0] e;
    total++;
    if (is_data ? (data_q.size() == 0) : (inst_q.size() == 0)) begin
      bad++;
      $error("FAIL %s: got %h want <empty queue>", tag, obs);
    end else begin
      e = is_data ? data_q.pop_front() : inst_q.pop_front();
      assert (obs === e) else begin
        bad++;
        $error("FAIL %s: got %h want %h", tag, obs, e);
      end
    end
  endtask

  task automatic run_txn(input bit is_data, input bit wr, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wen,
                         input logic [31:0] rd, input int ad_dly, input int dt_dly);
    bit found;
    bit is_rd;
    logic [3:0] exp_wen;
    is_rd = !(is_data && wr);
    exp_wen = (is_data && wr) ? wen : 4'b0000;
    cyc();
    if (is_data) begin
      i_data_req = 1'b1; i_data_wr = wr; i_data_wen = wen;
      i_data_addr = addr; i_data_wdata = wdata;
    end else begin
      i_inst_req = 1'b1; i_inst_addr = addr;
    end
    if (is_rd) begin
      if (is_data) data_q.push_back(rd);
      else inst_q.push_back(rd);
    end
    n_txn++;
    for (int i = 0; i < ad_dly; i++) begin
      cyc();
      i_bus_addr_ok = 1'b0;
      smp();
      chk1("rnd_req_hold", o_bus_req, 1'b1);
    end
    cyc();
    i_bus_addr_ok = 1'b1;
    smp();
    chk1("rnd_req", o_bus_req, 1'b1);
    chk("rnd_addr", o_bus_addr, addr);
    chk1("rnd_wr", o_bus_wr, is_data && wr);
    chk("rnd_wen", {28'h0, o_bus_wen}, {28'h0, exp_wen});
    for (int i = 0; i < dt_dly - 1; i++) begin
      cyc();
      i_bus_addr_ok = 1'b0;
      i_bus_data_ok = 1'b0;
    end
    cyc();
    i_bus_addr_ok = 1'b0;
    i_bus_data_ok = 1'b1;
    i_bus_rdata = rd;
    found = 1'b0;
    for (int k = 0; k < 4 && !found; k++) begin
      cyc();
      i_bus_data_ok = 1'b0;
      i_bus_rdata = $urandom;
      smp();
      if (is_data ? o_data_done : o_inst_done) begin
        found = 1'b1;
        if (!is_data) pop_chk("rnd_inst_rdata", 1'b0, o_inst_rdata);
        else if (!wr) begin
          pop_chk("rnd_data_rdata", 1'b1, o_data_rdata);
          last_drd = rd;
        end else chk("rnd_wr_keeps_rdata", o_data_rdata, last_drd);
      end
    end
    total++;
    assert (found) else begin
      bad++;
      $error("FAIL rnd_done_timeout: got no done want done within 4 cycles");
    end
    cyc();
    i_inst_req = 1'b0;
    i_data_req = 1'b0;
  endtask

  initial begin
    bit          r_is_data, r_wr;
    logic [31:0] r_addr, r_wdata, r_rd;
    logic [3:0]  r_wen;

    // reset
    rst = 1'b1;
    cyc(); cyc();
    rst = 1'b0;
    smp();
    chk("rst_state", {30'h0, o_dbg_state}, {30'h0, ST_IDLE});
    chk1("rst_bus_req", o_bus_req, 1'b0);
    chk("rst_bus_addr", o_bus_addr, 32'h0);
    chk1("rst_inst_done", o_inst_done, 1'b0);
    chk1("rst_data_done", o_data_done, 1'b0);
    chk("rst_inst_rdata", o_inst_rdata, 32'h0);
    chk1("rst_bus_err", o_bus_err, 1'b0);

    // single fetch, addr_ok immediate, data_ok next cycle; req held into RESP
    cyc();
    i_inst_req = 1'b1; i_inst_addr = 32'hBFC00000;
    inst_q.push_back(32'h24080001);
    n_txn++;
    smp();
    chk1("f_c0_stall", o_inst_stallreq, 1'b1);
    chk1("f_c0_req", o_bus_req, 1'b0);
    cyc();
    i_bus_addr_ok = 1'b1;
    smp();
    chk1("f_c1_req", o_bus_req, 1'b1);
    chk("f_c1_addr", o_bus_addr, 32'hBFC00000);
    chk("f_c1_wen", {28'h0, o_bus_wen}, 32'h0);
    chk1("f_c1_stall", o_inst_stallreq, 1'b1);
    cyc();
    i_bus_addr_ok = 1'b0; i_bus_data_ok = 1'b1; i_bus_rdata = 32'h24080001;
    smp();
    chk1("f_c2_req", o_bus_req, 1'b0);
    chk("f_c2_state", {30'h0, o_dbg_state}, {30'h0, ST_WAIT});
    chk1("f_c2_stall", o_inst_stallreq, 1'b1);
    chk1("f_c2_done", o_inst_done, 1'b0);
    cyc();
    i_bus_data_ok = 1'b0; i_bus_rdata = 32'h0;
    smp();
    chk1("f_c3_done", o_inst_done, 1'b1);
    pop_chk("f_c3_rdata", 1'b0, o_inst_rdata);
    chk1("f_c3_stall", o_inst_stallreq, 1'b0);
    chk1("f_c3_req", o_bus_req, 1'b0);
    cyc();
    i_inst_req = 1'b0;
    smp();
    chk1("f_c4_done", o_inst_done, 1'b0);
    chk1("f_c4_req", o_bus_req, 1'b0);
    chk("f_c4_state", {30'h0, o_dbg_state}, {30'h0, ST_IDLE});

    // simultaneous fetch and data read: data first
    cyc();
    i_inst_req = 1'b1; i_inst_addr = 32'hBFC00004;
    i_data_req = 1'b1; i_data_wr = 1'b0; i_data_wen = 4'hF; i_data_addr = 32'h80001000;
    data_q.push_back(32'h12345678);
    inst_q.push_back(32'h3C1D0000);
    n_txn += 2;
    cyc();
    i_bus_addr_ok = 1'b1;
    smp();
    chk("s_c1_addr", o_bus_addr, 32'h80001000);
    chk("s_c1_wen", {28'h0, o_bus_wen}, 32'h0);
    chk1("s_c1_wr", o_bus_wr, 1'b0);
    cyc();
    i_bus_addr_ok = 1'b0; i_bus_data_ok = 1'b1; i_bus_rdata = 32'h12345678;
    cyc();
    i_bus_data_ok = 1'b0;
    smp();
    chk1("s_c3_ddone", o_data_done, 1'b1);
    chk1("s_c3_idone", o_inst_done, 1'b0);
    pop_chk("s_c3_drdata", 1'b1, o_data_rdata);
    last_drd = 32'h12345678;
    chk1("s_c3_istall", o_inst_stallreq, 1'b1);
    cyc();
    i_data_req = 1'b0;
    smp();
    chk1("s_c4_req", o_bus_req, 1'b0);
    cyc();
    i_bus_addr_ok = 1'b1;
    smp();
    chk1("s_c5_req", o_bus_req, 1'b1);
    chk("s_c5_addr", o_bus_addr, 32'hBFC00004);
    cyc();
    i_bus_addr_ok = 1'b0; i_bus_data_ok = 1'b1; i_bus_rdata = 32'h3C1D0000;
    smp();
    chk1("s_c6_idone", o_inst_done, 1'b0);
    cyc();
    i_bus_data_ok = 1'b0;
    smp();
    chk1("s_c7_idone", o_inst_done, 1'b1);
    pop_chk("s_c7_irdata", 1'b0, o_inst_rdata);
    cyc();
    i_inst_req = 1'b0;

    // data write, addr_ok delayed 3 cycles
    cyc();
    i_data_req = 1'b1; i_data_wr = 1'b1; i_data_wen = 4'b0011;
    i_data_addr = 32'h80002000; i_data_wdata = 32'hDEADBEEF;
    n_txn++;
    for (int i = 0; i < 4; i++) begin
      cyc();
      i_bus_addr_ok = (i == 3);
      smp();
      chk1("w_req_held", o_bus_req, 1'b1);
      chk("w_addr", o_bus_addr, 32'h80002000);
      chk("w_wdata", o_bus_wdata, 32'hDEADBEEF);
      chk("w_wen", {28'h0, o_bus_wen}, 32'h3);
      chk1("w_wr", o_bus_wr, 1'b1);
    end
    cyc();
    i_bus_addr_ok = 1'b0; i_bus_data_ok = 1'b1; i_bus_rdata = 32'hFFFFFFFF;
    smp();
    chk1("w_req_drop", o_bus_req, 1'b0);
    cyc();
    i_bus_data_ok = 1'b0;
    smp();
    chk1("w_done", o_data_done, 1'b1);
    chk("w_rdata_kept", o_data_rdata, last_drd);
    cyc();
    i_data_req = 1'b0; i_data_wr = 1'b0;

    // randomised transactions through the scoreboard
    for (int n = 0; n < 8; n++) begin
      r_is_data = 1'($urandom_range(0, 1));
      r_wr = r_is_data ? 1'($urandom_range(0, 1)) : 1'b0;
      r_addr = $urandom;
      r_wdata = $urandom;
      r_wen = 4'($urandom_range(1, 15));
      r_rd = $urandom;
      run_txn(r_is_data, r_wr, r_addr, r_wdata, r_wen, r_rd,
              $urandom_range(0, 2), $urandom_range(1, 2));
    end

    // watchdog (TIMEOUT=4 instance), then reset while stuck in WAIT
    cyc();
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    cyc();
    i_data_req = 1'b1; i_data_wr = 1'b0; i_data_addr = 32'h80003000;
    n_txn++;
    cyc();
    i_bus_addr_ok = 1'b1;
    smp();
    chk("t_c1_state", {30'h0, t_dbg_state}, {30'h0, ST_ADDR});
    chk1("t_c1_err", t_bus_err, 1'b0);
    cyc();
    i_bus_addr_ok = 1'b0;
    cyc();
    cyc();
    smp();
    chk1("t_c4_err", t_bus_err, 1'b0);
    cyc();
    smp();
    chk1("t_c5_err", t_bus_err, 1'b1);
    chk1("t_c5_main_err", o_bus_err, 1'b0);
    chk("t_c5_state", {30'h0, t_dbg_state}, {30'h0, ST_WAIT});
    cyc();
    smp();
    chk1("t_c6_err_sticky", t_bus_err, 1'b1);
    chk1("t_c6_dstall", o_data_stallreq, 1'b1);
    cyc();
    rst = 1'b1; i_data_req = 1'b0;
    cyc();
    rst = 1'b0; i_bus_data_ok = 1'b1; i_bus_rdata = 32'hAAAA5555;
    smp();
    chk("r_state", {30'h0, o_dbg_state}, {30'h0, ST_IDLE});
    chk("r_t_state", {30'h0, t_dbg_state}, {30'h0, ST_IDLE});
    chk1("r_bus_req", o_bus_req, 1'b0);
    chk1("r_bus_wr", o_bus_wr, 1'b0);
    chk("r_bus_addr", o_bus_addr, 32'h0);
    chk("r_bus_wdata", o_bus_wdata, 32'h0);
    chk("r_data_rdata", o_data_rdata, 32'h0);
    chk("r_inst_rdata", o_inst_rdata, 32'h0);
    chk1("r_t_err", t_bus_err, 1'b0);
    chk1("r_data_done", o_data_done, 1'b0);
    cyc();
    i_bus_data_ok = 1'b0;
    smp();
    chk1("r_late_ok_done", o_data_done, 1'b0);
    chk("r_late_ok_rdata", o_data_rdata, 32'h0);
    chk("r_late_ok_state", {30'h0, o_dbg_state}, {30'h0, ST_IDLE});

    // final report
    chk1("main_err_never", o_bus_err, 1'b0);
    chk("txn_count", req_rises, n_txn);
    chk("inst_q_empty", inst_q.size(), 0);
    chk("data_q_empty", data_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
- Shares one SRAM-like unified memory bus between the instruction-fetch requester (IF) and the data-access requester (MEM stage).
- Serialises transactions with one outstanding at a time. Data has fixed priority over fetch.
- Sequences the bus address/data handshakes and returns read data with a one-cycle done pulse.
- Emits per-requester stall requests that feed the pipeline stall controller.

Parameters:
- TIMEOUT, 255: cycles a transaction may sit in ADDR/WAIT before bus_err sets. 0 disables the watchdog.
- CW, 8: width of the watchdog counter. Must satisfy TIMEOUT < 2^CW.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  reset; synchronous, active-high
- inst_req  in  1  fetch request; held with inst_addr until inst_done
- inst_addr  in  32  fetch address
- inst_rdata  out  32  fetched word, valid when inst_done
- inst_done  out  1  one-cycle completion pulse
- inst_stallreq  out  1  fetch stall request
- data_req  in  1  data request; held with other data_* inputs until data_done
- data_wr  in  1  1 = write, 0 = read
- data_wen  in  4  byte enables for writes
- data_addr  in  32  data address
- data_wdata  in  32  write data
- data_rdata  out  32  read data, valid when data_done on a read
- data_done  out  1  one-cycle completion pulse
- data_stallreq  out  1  data stall request
- bus_req  out  1  bus request
- bus_wr  out  1  bus write
- bus_wen  out  4  bus byte enables; 4'b0000 for reads
- bus_addr  out  32  bus address
- bus_wdata  out  32  bus write data
- bus_addr_ok  in  1  address accepted
- bus_data_ok  in  1  data phase complete
- bus_rdata  in  32  read data, valid with bus_data_ok
- bus_err  out  1  sticky watchdog error

Behaviour:
- State machine: IDLE, ADDR, WAIT, RESP. All bus_* outputs and done/rdata outputs are registered.
- IDLE: if data_req, latch the data request, set owner=DATA, go to ADDR. Else if inst_req, latch the fetch request (bus_wr=0, bus_wen=0), set owner=INST, go to ADDR. Else stay in IDLE.
- ADDR: bus_req=1 with the latched fields. When bus_addr_ok=1 at a clock edge, deassert bus_req and go to WAIT.
- WAIT: bus_data_ok is ignored in ADDR; it counts only in WAIT. When bus_data_ok=1:
  - capture bus_rdata into the owner's rdata register, on reads only;
  - go to RESP.
- RESP:
  - owner's done=1 for exactly this cycle; return to IDLE.
  - A request still asserted during RESP is never re-accepted. New arbitration happens only in IDLE, one cycle later.
- Minimum latency: request seen in IDLE at cycle 0, done at cycle 3. Maximum throughput is one transaction per 4 cycles.
- The non-owner's request waits and is not preempted. A data_req arriving while a fetch is in flight is served at the next IDLE, ahead of any pending fetch.
- Stall requests (combinational):
  - inst_stallreq = inst_req & ~inst_done
  - data_stallreq = data_req & ~data_done
- data_rdata/inst_rdata hold their last captured value. Writes do not update data_rdata.
- Watchdog:
  - counter clears on entry to ADDR and increments each cycle in ADDR or WAIT, saturating.
  - when it reaches TIMEOUT (TIMEOUT≠0), bus_err sets and stays set until rst.
  - the transaction is not aborted.
- Reset (any state, including mid-transaction):
  - next edge forces IDLE;
  - bus_req=0, bus_wr=0, bus_wen=0, bus_addr=0, bus_wdata=0;
  - done=0, rdata=0, bus_err=0, counter=0.
- Requesters must hold req and fields stable until done. Behaviour when a requester violates this is undefined.
- A bus_data_ok in the same cycle as bus_addr_ok is not counted. The slave must return data no earlier than one cycle after the address handshake.

Test Plan:
- Single fetch, inst_addr=0xBFC00000, addr_ok immediate, data_ok next cycle with rdata=0x24080001 -> bus_req high for 1 cycle; inst_done at cycle 3; inst_rdata=0x24080001; inst_stallreq high in cycles 0–2.
- Simultaneous inst_req and data_req (read 0x80001000, rdata=0x12345678) -> data served first; data_done at cycle 3; fetch enters ADDR at cycle 5; inst_done at cycle 7.
- Data write, wen=4'b0011, wdata=0xDEADBEEF, addr_ok delayed 3 cycles -> bus_req held 4 cycles with stable fields; data_done pulses; data_rdata unchanged.
- Request still held during RESP -> no second bus_req until after IDLE; exactly one transaction per request.
- TIMEOUT=4, slave never asserts data_ok -> bus_err rises 4 cycles after ADDR entry; assert rst -> IDLE, all outputs 0, bus_err=0.
- rst asserted while in WAIT -> next cycle IDLE, no done pulse; a later data_ok is ignored.
